clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 57 +++++
 rtl/tick_gen.sv | 67 ++++++
 rtl/clock_set_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types, field widths and calendar helpers for the clock-setting controller.
package clock_pkg;

  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 14;
  localparam int unsigned SEL_W   = 3;

  localparam int unsigned YEAR_MAX  = 9999;
  localparam int unsigned MONTH_MAX = 12;
  localparam int unsigned HOUR_MAX  = 23;
  localparam int unsigned MIN_MAX   = 59;

  typedef enum logic [SEL_W-1:0] {
    RUN     = 3'd0,
    S_YEAR  = 3'd1,
    S_MONTH = 3'd2,
    S_DAY   = 3'd3,
    S_HOUR  = 3'd4,
    S_MIN   = 3'd5
  } state_t;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   minute;
  } datetime_t;

  localparam datetime_t SHADOW_RST = '{
    year:   YEAR_W'(2024),
    month:  MONTH_W'(1),
    day:    DAY_W'(1),
    hour:   HOUR_W'(0),
    minute: MIN_W'(0)
  };

  // Gregorian month length; century years are leap only when divisible by 400.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic [YEAR_W-1:0]  year);
    logic leap;
    leap = ((year % YEAR_W'(400)) == YEAR_W'(0)) ||
           (((year % YEAR_W'(4)) == YEAR_W'(0)) && ((year % YEAR_W'(100)) != YEAR_W'(0)));
    case (month)
      MONTH_W'(2):  days_in_month = leap ? DAY_W'(29) : DAY_W'(28);
      MONTH_W'(4),
      MONTH_W'(6),
      MONTH_W'(9),
      MONTH_W'(11): days_in_month = DAY_W'(30);
      default:      days_in_month = DAY_W'(31);
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler and blink-phase divider; both enables describe the coming cycle.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic set_en,
  output logic tick,
  output logic blink
);

  localparam int unsigned CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HALF   = ((CLK_HZ / 2) > 0) ? (CLK_HZ / 2) : 1;
  localparam int unsigned HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_HZ - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              run_q;
  logic [HALF_W-1:0] hcnt;
  logic              set_q;

  // The first enabled cycle after a disabled one holds the count at 0.
  always_comb begin
    cnt_d = '0;
    if (run_en && run_q) begin
      cnt_d = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      run_q <= 1'b1;
      tick  <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      run_q <= run_en;
      tick  <= run_en && (cnt_d == CNT_LAST);
    end
  end

  // Blink restarts high whenever editing begins, then toggles every half period.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt  <= '0;
      set_q <= 1'b0;
      blink <= 1'b0;
    end else if (!set_en) begin
      hcnt  <= '0;
      set_q <= 1'b0;
      blink <= 1'b0;
    end else if (!set_q) begin
      hcnt  <= '0;
      set_q <= 1'b1;
      blink <= 1'b1;
    end else if (hcnt == HALF_LAST) begin
      hcnt  <= '0;
      blink <= ~blink;
    end else begin
      hcnt  <= hcnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven date/time setting FSM with shadow registers, load pulse and 1 Hz tick.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_btn,
  input  logic               inc_btn,
  input  logic [MIN_W-1:0]   cur_min,
  input  logic [HOUR_W-1:0]  cur_hour,
  input  logic [DAY_W-1:0]   cur_day,
  input  logic [MONTH_W-1:0] cur_month,
  input  logic [YEAR_W-1:0]  cur_year,
  output logic               tick,
  output logic               load,
  output logic [MIN_W-1:0]   set_min,
  output logic [HOUR_W-1:0]  set_hour,
  output logic [DAY_W-1:0]   set_day,
  output logic [MONTH_W-1:0] set_month,
  output logic [YEAR_W-1:0]  set_year,
  output logic [SEL_W-1:0]   sel_field,
  output logic               blink
);

  state_t           state;
  state_t           state_d;
  datetime_t        shadow;
  datetime_t        shadow_d;
  logic             load_d;
  logic             mode_q;
  logic             inc_q;
  logic             mode_ev;
  logic             inc_ev;
  logic [DAY_W-1:0] dim_c;

  // Copies reset high so a button held through reset does not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b1;
      inc_q  <= 1'b1;
    end else begin
      mode_q <= mode_btn;
      inc_q  <= inc_btn;
    end
  end

  assign mode_ev = mode_btn & ~mode_q;
  assign inc_ev  = inc_btn & ~inc_q & ~mode_ev;
  assign dim_c   = days_in_month(shadow.month, shadow.year);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      shadow <= SHADOW_RST;
      load   <= 1'b0;
    end else begin
      state  <= state_d;
      shadow <= shadow_d;
      load   <= load_d;
    end
  end

  always_comb begin
    state_d = state;
    if (mode_ev) begin
      case (state)
        RUN:     state_d = S_YEAR;
        S_YEAR:  state_d = S_MONTH;
        S_MONTH: state_d = S_DAY;
        S_DAY:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Shadow edits and load request; each field wraps to its own minimum.
  always_comb begin
    shadow_d = shadow;
    load_d   = 1'b0;
    case (state)
      RUN: begin
        if (mode_ev) begin
          shadow_d = '{year: cur_year, month: cur_month, day: cur_day,
                       hour: cur_hour, minute: cur_min};
        end
      end
      S_YEAR: begin
        if (inc_ev) begin
          shadow_d.year = (shadow.year >= YEAR_W'(YEAR_MAX)) ? '0 : shadow.year + YEAR_W'(1);
        end
      end
      S_MONTH: begin
        if (mode_ev) begin
          if (shadow.day > dim_c) shadow_d.day = dim_c;
        end else if (inc_ev) begin
          shadow_d.month = (shadow.month >= MONTH_W'(MONTH_MAX)) ? MONTH_W'(1)
                                                                 : shadow.month + MONTH_W'(1);
        end
      end
      S_DAY: begin
        if (inc_ev) begin
          shadow_d.day = (shadow.day >= dim_c) ? DAY_W'(1) : shadow.day + DAY_W'(1);
        end
      end
      S_HOUR: begin
        if (inc_ev) begin
          shadow_d.hour = (shadow.hour >= HOUR_W'(HOUR_MAX)) ? '0 : shadow.hour + HOUR_W'(1);
        end
      end
      S_MIN: begin
        if (mode_ev) begin
          load_d = 1'b1;
        end else if (inc_ev) begin
          shadow_d.minute = (shadow.minute >= MIN_W'(MIN_MAX)) ? '0
                                                               : shadow.minute + MIN_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Prescaler pauses through editing and the load cycle so the next second is full length.
  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .run_en ((state_d == RUN) && !load_d),
    .set_en (state_d != RUN),
    .tick   (tick),
    .blink  (blink)
  );

  assign sel_field = SEL_W'(state);
  assign set_year  = shadow.year;
  assign set_month = shadow.month;
  assign set_day   = shadow.day;
  assign set_hour  = shadow.hour;
  assign set_min   = shadow.minute;

endmodule
